if_stage: RTL and testbench

IF_STAGE -- requirements
Module: if_stage

---
 rtl/if_stage.sv | 134 +++++++++++++
 tb/tb_if_stage.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// Instruction fetch stage: owns the fetch PC, drives instruction memory and
// fills the IF/ID pipeline register. A one-entry hold buffer keeps a word
// that arrives while downstream is stalled, and an HLT opcode parks the
// stage until a branch redirect restarts it.
module if_stage #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [15:0] branch_target,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_data,
  input  logic        imem_valid,
  output logic [15:0] pc,
  output logic [15:0] if_id_instr,
  output logic [15:0] if_id_pc,
  output logic        if_id_valid,
  output logic        halted
);

  typedef enum logic [1:0] {
    StFetch = 2'd0,
    StHold  = 2'd1,
    StHalt  = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] if_id_instr_q, if_id_instr_d;
  logic [15:0] if_id_pc_q, if_id_pc_d;
  logic        if_id_valid_q, if_id_valid_d;
  logic [15:0] hold_q, hold_d;

  logic [15:0] pc_inc;
  logic        data_is_hlt;
  logic        hold_is_hlt;

  assign pc_inc      = pc_q + 16'd2;
  assign data_is_hlt = (imem_data[15:12] == 4'hF);
  assign hold_is_hlt = (hold_q[15:12] == 4'hF);

  // Outputs come straight from registered state only.
  assign imem_req    = (state_q == StFetch);
  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign halted      = (state_q == StHalt);
  assign if_id_instr = if_id_instr_q;
  assign if_id_pc    = if_id_pc_q;
  assign if_id_valid = if_id_valid_q;

  // Next-state logic: a redirect overrides everything, including stall.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    if_id_instr_d = if_id_instr_q;
    if_id_pc_d    = if_id_pc_q;
    if_id_valid_d = if_id_valid_q;
    hold_d        = hold_q;

    if (branch_taken) begin
      pc_d          = {branch_target[15:1], 1'b0};
      if_id_valid_d = 1'b0;
      hold_d        = 16'h0000;
      state_d       = StFetch;
    end else begin
      unique case (state_q)
        StFetch: begin
          if (imem_valid) begin
            if (stall) begin
              hold_d  = imem_data;
              state_d = StHold;
            end else begin
              if_id_instr_d = imem_data;
              if_id_pc_d    = pc_q;
              if_id_valid_d = 1'b1;
              if (data_is_hlt) begin
                state_d = StHalt;
              end else begin
                pc_d = pc_inc;
              end
            end
          end else if (!stall) begin
            if_id_valid_d = 1'b0;
          end
        end
        StHold: begin
          if (!stall) begin
            if_id_instr_d = hold_q;
            if_id_pc_d    = pc_q;
            if_id_valid_d = 1'b1;
            if (hold_is_hlt) begin
              state_d = StHalt;
            end else begin
              pc_d    = pc_inc;
              state_d = StFetch;
            end
          end
        end
        StHalt: begin
          // The HLT word leaves IF/ID once downstream takes it.
          if (!stall) begin
            if_id_valid_d = 1'b0;
          end
        end
        default: begin
          state_d = StFetch;
        end
      endcase
    end
  end

  // State registers with asynchronous active-high reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StFetch;
      pc_q          <= {RESET_PC[15:1], 1'b0};
      if_id_instr_q <= 16'h0000;
      if_id_pc_q    <= 16'h0000;
      if_id_valid_q <= 1'b0;
      hold_q        <= 16'h0000;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      if_id_instr_q <= if_id_instr_d;
      if_id_pc_q    <= if_id_pc_d;
      if_id_valid_q <= if_id_valid_d;
      hold_q        <= hold_d;
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Directed table-driven bench for if_stage. Each vector is applied for one
// clock and the registered outputs are compared 1 time unit after the edge.
module tb_if_stage;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        branch_taken;
  logic [15:0] branch_target;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic [15:0] imem_data;
  logic        imem_valid;
  logic [15:0] pc;
  logic [15:0] if_id_instr;
  logic [15:0] if_id_pc;
  logic        if_id_valid;
  logic        halted;

  if_stage #(.RESET_PC(16'h0000)) dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_data    (imem_data),
    .imem_valid   (imem_valid),
    .pc           (pc),
    .if_id_instr  (if_id_instr),
    .if_id_pc     (if_id_pc),
    .if_id_valid  (if_id_valid),
    .halted       (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        stall;
    logic        bt;
    logic [15:0] tgt;
    logic        valid;
    logic [15:0] data;
    logic [15:0] e_pc;
    logic        e_req;
    logic        e_halt;
    logic        e_v;
    logic [15:0] e_ifpc;
    logic [15:0] e_instr;
  } vec_t;

  vec_t vecs[$];
  int   n_vec;
  int   n_bad;

  task automatic add(input string name, input logic st, input logic bt, input logic [15:0] tgt,
                     input logic vl, input logic [15:0] dt, input logic [15:0] e_pc,
                     input logic e_req, input logic e_halt, input logic e_v,
                     input logic [15:0] e_ifpc, input logic [15:0] e_instr);
    vec_t v;
    v.name = name; v.stall = st; v.bt = bt; v.tgt = tgt; v.valid = vl; v.data = dt;
    v.e_pc = e_pc; v.e_req = e_req; v.e_halt = e_halt; v.e_v = e_v;
    v.e_ifpc = e_ifpc; v.e_instr = e_instr;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [15:0] e_pc, input logic e_req,
                       input logic e_halt, input logic e_v, input logic [15:0] e_ifpc,
                       input logic [15:0] e_instr);
    logic [66:0] act, exp;
    act = {pc, imem_addr, imem_req, halted, if_id_valid, if_id_pc, if_id_instr};
    exp = {e_pc, e_pc, e_req, e_halt, e_v, e_ifpc, e_instr};
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got pc=%h addr=%h req=%b halt=%b v=%b ifpc=%h instr=%h, want pc=%h addr=%h req=%b halt=%b v=%b ifpc=%h instr=%h",
               name, pc, imem_addr, imem_req, halted, if_id_valid, if_id_pc, if_id_instr,
               e_pc, e_pc, e_req, e_halt, e_v, e_ifpc, e_instr);
    end
  endtask

  task automatic drive(input logic st, input logic bt, input logic [15:0] tgt,
                       input logic vl, input logic [15:0] dt);
    stall = st; branch_taken = bt; branch_target = tgt; imem_valid = vl; imem_data = dt;
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    //   name            st bt tgt       vl data      pc        req hlt v  ifpc      instr
    add("fetch0",        0, 0, 16'h0000, 1, 16'h1234, 16'h0002, 1, 0, 1, 16'h0000, 16'h1234);
    add("fetch1",        0, 0, 16'h0000, 1, 16'h5678, 16'h0004, 1, 0, 1, 16'h0002, 16'h5678);
    add("bubble",        0, 0, 16'h0000, 0, 16'h0000, 16'h0004, 1, 0, 0, 16'h0002, 16'h5678);
    add("br_to_10",      0, 1, 16'h0010, 0, 16'h0000, 16'h0010, 1, 0, 0, 16'h0002, 16'h5678);
    add("lat_wait1",     0, 0, 16'h0000, 0, 16'h0000, 16'h0010, 1, 0, 0, 16'h0002, 16'h5678);
    add("lat_wait2",     0, 0, 16'h0000, 0, 16'h0000, 16'h0010, 1, 0, 0, 16'h0002, 16'h5678);
    add("lat_done",      0, 0, 16'h0000, 1, 16'hAAAA, 16'h0012, 1, 0, 1, 16'h0010, 16'hAAAA);
    add("stall_cap",     1, 0, 16'h0000, 1, 16'hBBBB, 16'h0012, 0, 0, 1, 16'h0010, 16'hAAAA);
    add("hold_stall",    1, 0, 16'h0000, 0, 16'h0000, 16'h0012, 0, 0, 1, 16'h0010, 16'hAAAA);
    add("hold_release",  0, 0, 16'h0000, 0, 16'h0000, 16'h0014, 1, 0, 1, 16'h0012, 16'hBBBB);
    add("br_drop_word",  0, 1, 16'h0041, 1, 16'hCCCC, 16'h0040, 1, 0, 0, 16'h0012, 16'hBBBB);
    add("fetch_40",      0, 0, 16'h0000, 1, 16'hDDDD, 16'h0042, 1, 0, 1, 16'h0040, 16'hDDDD);
    add("br_to_20",      0, 1, 16'h0020, 0, 16'h0000, 16'h0020, 1, 0, 0, 16'h0040, 16'hDDDD);
    add("hlt_fetch",     0, 0, 16'h0000, 1, 16'hF000, 16'h0020, 0, 1, 1, 16'h0020, 16'hF000);
    add("halt_consume",  0, 0, 16'h0000, 1, 16'h1111, 16'h0020, 0, 1, 0, 16'h0020, 16'hF000);
    add("halt_exit",     0, 1, 16'h0100, 0, 16'h0000, 16'h0100, 1, 0, 0, 16'h0020, 16'hF000);
    add("fetch_100",     0, 0, 16'h0000, 1, 16'h2222, 16'h0102, 1, 0, 1, 16'h0100, 16'h2222);
    add("hlt_stalled",   1, 0, 16'h0000, 1, 16'hF00F, 16'h0102, 0, 0, 1, 16'h0100, 16'h2222);
    add("hold_to_halt",  0, 0, 16'h0000, 0, 16'h0000, 16'h0102, 0, 1, 1, 16'h0102, 16'hF00F);
    add("halt_stall",    1, 0, 16'h0000, 0, 16'h0000, 16'h0102, 0, 1, 1, 16'h0102, 16'hF00F);
    add("halt_drain",    0, 0, 16'h0000, 0, 16'h0000, 16'h0102, 0, 1, 0, 16'h0102, 16'hF00F);
    add("br_to_fffe",    0, 1, 16'hFFFE, 0, 16'h0000, 16'hFFFE, 1, 0, 0, 16'h0102, 16'hF00F);
    add("pc_wrap",       0, 0, 16'h0000, 1, 16'h3333, 16'h0000, 1, 0, 1, 16'hFFFE, 16'h3333);
    add("stall_cap2",    1, 0, 16'h0000, 1, 16'h4444, 16'h0000, 0, 0, 1, 16'hFFFE, 16'h3333);
    add("br_in_stall",   1, 1, 16'h0200, 0, 16'h0000, 16'h0200, 1, 0, 0, 16'hFFFE, 16'h3333);
    add("after_flush",   0, 0, 16'h0000, 1, 16'h5555, 16'h0202, 1, 0, 1, 16'h0200, 16'h5555);
    add("wait_stalled",  1, 0, 16'h0000, 0, 16'h0000, 16'h0202, 1, 0, 1, 16'h0200, 16'h5555);

    // Reset state.
    rst = 1'b1;
    drive(0, 0, 16'h0000, 0, 16'h0000);
    @(posedge clk);
    #1;
    check("reset_state", 16'h0000, 1, 0, 0, 16'h0000, 16'h0000);
    rst = 1'b0;

    foreach (vecs[i]) begin
      drive(vecs[i].stall, vecs[i].bt, vecs[i].tgt, vecs[i].valid, vecs[i].data);
      @(posedge clk);
      #1;
      check(vecs[i].name, vecs[i].e_pc, vecs[i].e_req, vecs[i].e_halt, vecs[i].e_v,
            vecs[i].e_ifpc, vecs[i].e_instr);
    end

    // Async reset mid-fetch takes effect without a clock edge.
    drive(0, 0, 16'h0000, 0, 16'h0000);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst", 16'h0000, 1, 0, 0, 16'h0000, 16'h0000);
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive(0, 0, 16'h0000, 1, 16'h7777);
    @(posedge clk);
    #1;
    check("post_rst_fetch", 16'h0002, 1, 0, 1, 16'h0000, 16'h7777);

    // Reset while in HOLD abandons the buffered word.
    drive(1, 0, 16'h0000, 1, 16'h8888);
    @(posedge clk);
    #1;
    check("hold_again", 16'h0002, 0, 0, 1, 16'h0000, 16'h7777);
    rst = 1'b1;
    #1;
    check("rst_in_hold", 16'h0000, 1, 0, 0, 16'h0000, 16'h0000);
    rst = 1'b0;
    drive(0, 0, 16'h0000, 0, 16'h0000);
    @(posedge clk);
    #1;
    check("rst_hold_clear", 16'h0000, 1, 0, 0, 16'h0000, 16'h0000);
    drive(0, 0, 16'h0000, 1, 16'h9999);
    @(posedge clk);
    #1;
    check("rst_hold_fetch", 16'h0002, 1, 0, 1, 16'h0000, 16'h9999);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
